// File: rtl/oven_pkg.sv
// rtl/oven_pkg.sv - shared types and defaults for the oven front-end controller
package oven_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ENTRY   = 2'd1,
    PREHEAT = 2'd2,
    HOLD    = 2'd3
  } oven_state_t;

  localparam int TEMP_W       = 10;
  localparam int BCD_W        = 4;
  localparam int AMBIENT_TEMP = 65;
  localparam int MIN_TEMP     = 150;
  localparam int MAX_TEMP     = 550;
  localparam int HYST         = 5;

  function automatic logic bcd_ok(input logic [BCD_W-1:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_accumulator.sv
// rtl/bcd_accumulator.sv - builds a decimal value of up to three BCD keypad digits
module bcd_accumulator
  import oven_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit,
  input  logic       valid,
  input  logic       clear,
  output logic [9:0] value,
  output logic [1:0] count
);

  logic accept;

  // Capped at three digits, so value never exceeds 999 and fits in 10 bits.
  assign accept = valid && bcd_ok(digit) && (count != 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (accept) begin
      value <= value * 10'd10 + {6'b0, digit};
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/oven_control.sv
// rtl/oven_control.sv - keypad target entry, range check and hysteresis heater control
module oven_control #(
  parameter int MIN_TEMP = oven_pkg::MIN_TEMP,
  parameter int MAX_TEMP = oven_pkg::MAX_TEMP,
  parameter int HYST     = oven_pkg::HYST
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       digitValid,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       cancel,
  input  logic [9:0] currentTemp,
  input  logic       preheated,
  output logic [9:0] targetTemp,
  output logic       tempInputDone,
  output logic       heat,
  output logic       ready,
  output logic       error
);

  import oven_pkg::*;

  localparam logic [TEMP_W-1:0] MIN_T  = TEMP_W'(MIN_TEMP);
  localparam logic [TEMP_W-1:0] MAX_T  = TEMP_W'(MAX_TEMP);
  localparam logic [TEMP_W:0]   HYST_T = (TEMP_W + 1)'(HYST);

  oven_state_t       state, state_n;
  logic [TEMP_W-1:0] value;
  logic [1:0]        count;
  logic              entry_phase, acc_valid, acc_clear, in_range;
  logic              heat_on, heat_off;
  logic [TEMP_W-1:0] target_n;
  logic              done_n, heat_n, ready_n, error_n;

  assign entry_phase = (state == IDLE) || (state == ENTRY);
  assign acc_valid   = digitValid && !enter && !cancel && entry_phase;
  assign in_range    = (count != 2'd0) && (value >= MIN_T) && (value <= MAX_T);
  assign acc_clear   = cancel || ((state == ENTRY) && enter && !in_range);

  // 11-bit compare keeps target - HYST from wrapping.
  assign heat_on  = {1'b0, currentTemp} < ({1'b0, targetTemp} - HYST_T);
  assign heat_off = currentTemp >= targetTemp;

  bcd_accumulator u_acc (
    .clk   (clk),
    .reset (reset),
    .digit (digit),
    .valid (acc_valid),
    .clear (acc_clear),
    .value (value),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      targetTemp    <= '0;
      tempInputDone <= 1'b0;
      heat          <= 1'b0;
      ready         <= 1'b0;
      error         <= 1'b0;
    end else begin
      state         <= state_n;
      targetTemp    <= target_n;
      tempInputDone <= done_n;
      heat          <= heat_n;
      ready         <= ready_n;
      error         <= error_n;
    end
  end

  always_comb begin
    state_n = state;
    if (cancel) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (acc_valid && bcd_ok(digit)) state_n = ENTRY;
        ENTRY:   if (enter && in_range)          state_n = PREHEAT;
        PREHEAT: if (preheated)                  state_n = HOLD;
        HOLD:    state_n = HOLD;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    target_n = targetTemp;
    heat_n   = 1'b0;
    error_n  = 1'b0;
    if (cancel) begin
      target_n = '0;
    end else begin
      case (state)
        ENTRY: begin
          if (enter) begin
            if (in_range) target_n = value;
            else          error_n  = 1'b1;
          end
        end
        PREHEAT, HOLD: begin
          heat_n = heat;
          if (heat_on)       heat_n = 1'b1;
          else if (heat_off) heat_n = 1'b0;
        end
        default: heat_n = 1'b0;
      endcase
    end
    done_n  = (state_n == PREHEAT) || (state_n == HOLD);
    ready_n = (state_n == HOLD);
  end

endmodule

// File: tb/tb_oven_control.sv
// tb/tb_oven_control.sv - scoreboard bench for oven_control against a digit-list reference model
module tb_oven_control;

  localparam int MIN_T = 150;
  localparam int MAX_T = 550;
  localparam int HYS   = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       digitValid = 1'b0;
  logic [3:0] digit = '0;
  logic       enter = 1'b0;
  logic       cancel = 1'b0;
  logic [9:0] currentTemp = '0;
  logic       preheated = 1'b0;
  logic [9:0] targetTemp;
  logic       tempInputDone, heat, ready, error;

  oven_control dut (
    .clk           (clk),
    .reset         (reset),
    .digitValid    (digitValid),
    .digit         (digit),
    .enter         (enter),
    .cancel        (cancel),
    .currentTemp   (currentTemp),
    .preheated     (preheated),
    .targetTemp    (targetTemp),
    .tempInputDone (tempInputDone),
    .heat          (heat),
    .ready         (ready),
    .error         (error)
  );

  always #5 clk = ~clk;

  // Expected {targetTemp, tempInputDone, heat, ready, error} after each edge.
  logic [13:0] exp_q[$];
  event        async_chk;
  event        fin_ev;
  int          total = 0;
  int          bad = 0;

  // Reference model: keyed-in digits kept as a list, value folded on demand.
  int m_digits[$];
  bit m_entering, m_committed, m_hold, m_heat;
  int m_target;
  int cur_t = 65;
  bit pre = 1'b0;

  function automatic int fold(input int ds[$]);
    int v = 0;
    foreach (ds[i]) v = v * 10 + ds[i];
    return v;
  endfunction

  task automatic model_reset();
    m_digits.delete();
    m_entering = 0; m_committed = 0; m_hold = 0; m_heat = 0; m_target = 0;
  endtask

  task automatic step(input bit c, input bit e, input bit d, input int dg);
    bit err;
    int v;
    @(negedge clk);
    cancel = c; enter = e; digitValid = d; digit = 4'(dg);
    currentTemp = 10'(cur_t); preheated = pre;
    err = 0;
    if (c) begin
      model_reset();
    end else if (m_committed) begin
      if (cur_t < m_target - HYS) m_heat = 1;
      else if (cur_t >= m_target) m_heat = 0;
      if (pre) m_hold = 1;
    end else if (e) begin
      if (m_entering) begin
        v = fold(m_digits);
        if (m_digits.size() > 0 && v >= MIN_T && v <= MAX_T) begin
          m_target = v; m_committed = 1; m_entering = 0;
        end else begin
          err = 1;
        end
        m_digits.delete();
      end
    end else if (d && dg <= 9) begin
      if (m_digits.size() < 3) m_digits.push_back(dg);
      m_entering = 1;
    end
    exp_q.push_back({10'(m_target), m_committed, m_heat, m_hold, err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic key(input int dg);
    step(0, 0, 1, dg);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    -> async_chk;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #1 -> async_chk;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Commit 350 from ambient, heat rises, then reset while heating.
    cur_t = 65;
    key(3); key(5); key(0); step(0, 1, 0, 0);
    idle(3);
    async_reset();
    key(3); step(0, 1, 0, 0); idle(1);
    step(1, 0, 0, 0);

    // Out-of-range entry then valid 200.
    key(9); key(9); step(0, 1, 0, 0); idle(1);
    key(2); key(0); key(0); step(0, 1, 0, 0); idle(2);
    step(1, 0, 0, 0);

    // Hysteresis sweep around 350.
    cur_t = 340;
    key(3); key(5); key(0); step(0, 1, 0, 0);
    idle(2);
    cur_t = 350; idle(2);
    cur_t = 346; idle(2);
    cur_t = 344; idle(2);
    step(1, 0, 0, 0);

    // Fourth digit and non-BCD digit ignored; preheated pulse latches ready.
    cur_t = 440;
    key(4); key(5); key(0); key(7); key(12); step(0, 1, 0, 0);
    idle(2);
    pre = 1; idle(1); pre = 0; idle(3);
    step(1, 0, 0, 0);

    // enter and cancel together during entry of 300.
    key(3); key(0); key(0); step(1, 1, 0, 0); idle(2);

    // Boundary targets.
    key(1); key(5); key(0); step(0, 1, 0, 0); idle(1); step(1, 0, 0, 0);
    key(5); key(5); key(0); step(0, 1, 0, 0); idle(1); step(1, 0, 0, 0);
    key(1); key(4); key(9); step(0, 1, 0, 0); idle(1);
    key(5); key(5); key(1); step(0, 1, 0, 0); idle(1); step(1, 0, 0, 0);

    for (int i = 0; i < 2000; i++) begin
      bit c, e, d;
      int dg;
      if (m_committed) cur_t = m_target - 12 + int'($urandom_range(0, 16));
      else             cur_t = int'($urandom_range(0, 700));
      pre = ($urandom_range(0, 19) == 0);
      c   = ($urandom_range(0, 59) == 0);
      e   = ($urandom_range(0, 7) == 0);
      d   = ($urandom_range(0, 2) == 0);
      dg  = int'($urandom_range(0, 15));
      if (m_digits.size() == 0 && $urandom_range(0, 1) == 1) dg = int'($urandom_range(1, 5));
      step(c, e, d, dg);
      if (i == 1000) async_reset();
    end
    pre = 0;
    idle(2);
    @(negedge clk);
    -> fin_ev;
  end

  initial begin
    fork
      forever begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
          logic [13:0] ex, got;
          ex  = exp_q.pop_front();
          got = {targetTemp, tempInputDone, heat, ready, error};
          total++;
          if (got !== ex) begin
            bad++;
            $display("FAIL outputs @%0t: got tt=%0d done=%b heat=%b ready=%b err=%b, exp tt=%0d done=%b heat=%b ready=%b err=%b",
                     $time, got[13:4], got[3], got[2], got[1], got[0],
                     ex[13:4], ex[3], ex[2], ex[1], ex[0]);
          end
        end
      end
      forever begin
        @(async_chk);
        #1;
        total++;
        if ({targetTemp, tempInputDone, heat, ready, error} !== 14'd0) begin
          bad++;
          $display("FAIL async_reset @%0t: got tt=%0d done=%b heat=%b ready=%b err=%b, exp all 0",
                   $time, targetTemp, tempInputDone, heat, ready, error);
        end
      end
      begin
        @(fin_ev);
        #1;
        total++;
        if (exp_q.size() != 0) begin
          bad++;
          $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      begin
        #500000;
        $display("FAIL timeout: got no finish, exp finish");
        $fatal(1);
      end
    join
  end

endmodule

// File: doc/oven_control.md
# oven_control

Front-end controller that sits directly upstream of the oven temperature model. It collects a target temperature from BCD keypad digits, validates it against a legal range, and publishes `targetTemp`/`tempInputDone` to the model. It then closes the loop by driving the model's `heat` input with hysteresis from the model's `currentTemp`, and reports `ready` once the model asserts `preheated`.

## Interface
- `MIN_TEMP`, 150: lowest accepted target (°F).
- `MAX_TEMP`, 550: highest accepted target (°F). Must be ≤ 999.
- `HYST`, 5: heater turn-on band below target. Must be ≤ `MIN_TEMP`.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high. Forces IDLE and clears all outputs.
- `digitValid` input 1: one-cycle strobe, `digit` is valid.
- `digit` input 4: BCD digit. Values 10–15 are ignored.
- `enter` input 1: one-cycle strobe, commit the entered value.
- `cancel` input 1: one-cycle strobe, abort to IDLE.
- `currentTemp` input 10: temperature from the model.
- `preheated` input 1: in-band flag from the model.
- `targetTemp` output 10: committed target, fed to the model.
- `tempInputDone` output 1: level signal, high while a valid target is committed.
- `heat` output 1: heater command to the model.
- `ready` output 1: high in HOLD.
- `error` output 1: one-cycle pulse when `enter` is given with an out-of-range value.

## Operation
- **Registers:** all outputs are registered. Reset value of every output is 0. The internal accumulator `value` (10 bits) resets to 0 and the digit count (2 bits) resets to 0.
- **States:** IDLE, ENTRY, PREHEAT, HOLD.
- **Input priority per cycle:** `cancel` > `enter` > `digitValid`. A lower-priority strobe in the same cycle is dropped.
- **IDLE:**
  - Valid digit: `value` = digit, count = 1, go to ENTRY.
  - `enter`: ignored, no `error`.
- **ENTRY:**
  - Valid digit with count < 3: `value` = `value`*10 + digit, count += 1.
  - Digit with count = 3: ignored. Max `value` is 999, so 10 bits never overflow.
  - `enter` with MIN_TEMP ≤ `value` ≤ MAX_TEMP:
    - `targetTemp` = `value`, `tempInputDone` = 1, go to PREHEAT.
  - `enter` out of range:
    - `error` = 1 for one cycle; `value` and count cleared; stay in ENTRY.
- **PREHEAT / HOLD heater control:** bang-bang with hysteresis, evaluated every cycle.
  - `heat` → 1 if `currentTemp` < `targetTemp` − HYST.
  - `heat` → 0 if `currentTemp` ≥ `targetTemp`.
  - Otherwise `heat` holds its value.
  - Compare is unsigned 11-bit. The subtraction cannot underflow because HYST ≤ MIN_TEMP.
- **PREHEAT → HOLD** when `preheated` is sampled 1. `ready` = 1 from the next cycle.
- **HOLD:**
  - Stays in HOLD even if `preheated` later drops.
  - `ready` stays 1; heater control continues.
- **`cancel` in any state:**
  - Next state IDLE.
  - `heat`, `tempInputDone`, `ready` and `targetTemp` clear to 0; `value` and count clear.
- **Digits and `enter` in PREHEAT/HOLD:** ignored. The target cannot be changed without `cancel`.

## Timing
- **Digit accumulation:** visible in `value` one cycle after the strobe.
- **Commit latency:** `targetTemp` and `tempInputDone` update on the edge that samples `enter`. The model sees them on its next edge.
- **Heater response:** `heat` reflects `currentTemp` with 1-cycle latency. Loop delay through the model is 2 cycles, which is acceptable given the hysteresis band.
- **First heater decision:** `heat` is evaluated in the first PREHEAT cycle. With `currentTemp` = 65, `heat` rises 1 cycle after entering PREHEAT.
- **`ready` latency:** 1 cycle after `preheated` is sampled high.
- **Mid-operation reset:** reset asserted at any point immediately (asynchronously) drives all outputs to 0. Operation resumes in IDLE on the first edge after deassertion.
- **Strobe handling:** strobes are not synchronized internally. Upstream must supply clean, single-cycle, clock-synchronous pulses.

## Structure
- **Shared package `oven_pkg`:**
  - State enum `oven_state_t` (IDLE, ENTRY, PREHEAT, HOLD).
  - `TEMP_W` = 10.
  - `BCD_W` = 4.
  - Defaults `AMBIENT_TEMP` = 65, `MIN_TEMP`, `MAX_TEMP`, `HYST`.
- **Sub-module `bcd_accumulator`:**
  - Inputs: digit, valid, clear.
  - Outputs: 10-bit value and digit count.
  - Handles the ×10 + digit arithmetic, the 3-digit limit and rejection of digits 10–15.
- **Top level:** FSM and hysteresis comparator.

## Test plan
1. Reset asserted mid-PREHEAT with `heat` = 1 → all outputs 0 asynchronously; after release, a digit 3 moves the FSM to ENTRY.
2. Digits 3,5,0 then `enter` with `currentTemp` = 65 → `targetTemp` = 350 and `tempInputDone` = 1 on the next edge; `heat` = 1 one cycle later.
3. Digits 9,9 then `enter` → `error` high for exactly 1 cycle, `tempInputDone` stays 0; next digits 2,0,0 plus `enter` → `targetTemp` = 200.
4. Target 350, HYST 5; sweep `currentTemp` 340→350→346→344 → `heat` is 1, then 0 at 350, stays 0 at 346, returns to 1 at 344, each change 1 cycle late.
5. Digits 4,5,0,7 (4th ignored), also digit 12, then `enter` → `targetTemp` = 450; `preheated` pulse → `ready` = 1 next cycle and stays 1 after `preheated` drops.
6. `enter` and `cancel` in the same cycle during ENTRY with `value` = 300 → IDLE, no commit, no `error`, all outputs 0.
